// File: rtl/multi_period_counter.sv
// multi_period_counter: CHANNELS independent period counters that share one tick.
// Each channel runs as a free-running wrap counter (mode 0) or an armed one-shot (mode 1).
// Build option: define MULTI_PERIOD_COUNTER_PRESCALE_EN to divide the shared tick by PRESCALE;
// when it is undefined the tick is always 1 and PRESCALE has no effect.
module multi_period_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [CHANNELS-1:0]          enable_in,
    input  logic [CHANNELS*WIDTH-1:0]    period_in,
    input  logic [CHANNELS-1:0]          mode_in,
    input  logic [CHANNELS-1:0]          start_in,
    output logic [CHANNELS*WIDTH-1:0]    count_out,
    output logic [CHANNELS-1:0]          tc_out,
    output logic [CHANNELS-1:0]          busy_out
);

    // Reject parameter values that cannot describe a working counter
    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_period_counter: CHANNELS must be >= 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("multi_period_counter: PRESCALE must be >= 1");
    end

    logic [CHANNELS-1:0][WIDTH-1:0] period_a;
    logic [CHANNELS-1:0][WIDTH-1:0] count_q;
    logic [CHANNELS-1:0][WIDTH-1:0] count_d;
    logic [CHANNELS-1:0]            tc_q;
    logic [CHANNELS-1:0]            tc_d;
    logic [CHANNELS-1:0]            busy_q;
    logic [CHANNELS-1:0]            busy_d;
    logic [CHANNELS-1:0]            armed_q;
    logic [CHANNELS-1:0]            armed_d;
    logic [CHANNELS-1:0]            zero_c;
    logic [CHANNELS-1:0]            term_c;
    logic [CHANNELS-1:0]            adv_c;
    logic                           tick_c;

    assign period_a  = period_in;
    assign count_out = count_q;
    assign tc_out    = tc_q;
    assign busy_out  = busy_q;

`ifdef MULTI_PERIOD_COUNTER_PRESCALE_EN
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q;

    assign tick_c = (pre_q == PRE_LAST);

    // Free-running shared divider, 0..PRESCALE-1, tick on the last value
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pre_q <= '0;
        end else if (tick_c) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end
`else
    assign tick_c = 1'b1;
`endif

    // Per-channel next state: period 0 dominates, then start, then advance
    always_comb begin
        count_d = count_q;
        tc_d    = '0;
        busy_d  = '0;
        armed_d = armed_q;
        zero_c  = '0;
        term_c  = '0;
        adv_c   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            zero_c[i] = (period_a[i] == '0);
            // period is nonzero whenever this matters, so period-1 never wraps
            term_c[i] = (count_q[i] >= (period_a[i] - WIDTH'(1)));
            adv_c[i]  = tick_c && enable_in[i] && !start_in[i] &&
                        (mode_in[i] ? armed_q[i] : !zero_c[i]);

            if (zero_c[i]) begin
                count_d[i] = '0;
                armed_d[i] = 1'b0;
            end else if (start_in[i]) begin
                count_d[i] = '0;
                armed_d[i] = mode_in[i];
            end else if (adv_c[i]) begin
                if (term_c[i]) begin
                    count_d[i] = '0;
                    tc_d[i]    = 1'b1;
                    armed_d[i] = 1'b0;
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end

            // Free-running channels never carry an arm, so a later switch to one-shot starts idle
            if (!mode_in[i]) begin
                armed_d[i] = 1'b0;
            end

            busy_d[i] = !zero_c[i] && (mode_in[i] ? armed_d[i] : enable_in[i]);
        end
    end

    // Output and arm registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
            tc_q    <= '0;
            busy_q  <= '0;
            armed_q <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: tb/tb_multi_period_counter.sv
// Directed bench for multi_period_counter: two 8-bit channels, hand-computed expectations.
module tb_multi_period_counter;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 2;
    localparam int unsigned PS = 4;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic [CH-1:0]   enable_in = '0;
    logic [CH-1:0]   mode_in = '0;
    logic [CH-1:0]   start_in = '0;
    logic [W-1:0]    p0 = '0;
    logic [W-1:0]    p1 = '0;
    logic [CH*W-1:0] period_in;
    logic [CH*W-1:0] count_out;
    logic [CH-1:0]   tc_out;
    logic [CH-1:0]   busy_out;
    logic [W-1:0]    c0;
    logic [W-1:0]    c1;

    int n_checks = 0;
    int n_pass   = 0;

    assign period_in = {p1, p0};
    assign c0 = count_out[W-1:0];
    assign c1 = count_out[2*W-1:W];

    always #5 clk_in = ~clk_in;

    multi_period_counter #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .PRESCALE (PS)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .enable_in (enable_in),
        .period_in (period_in),
        .mode_in   (mode_in),
        .start_in  (start_in),
        .count_out (count_out),
        .tc_out    (tc_out),
        .busy_out  (busy_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int exp_c[5];
        int exp_b[5];
        int exp_t[5];

        // Reset state
        repeat (2) step();
        check("rst_count", 32'(count_out), 0);
        check("rst_tc", 32'(tc_out), 0);
        check("rst_busy", 32'(busy_out), 0);

        // Mode 0, period 5, enable held
        p0 = 8'd5;
        enable_in = 2'b01;
        rst_in = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("m0_count", 32'(c0), 32'(k % 5));
            check("m0_tc", 32'(tc_out[0]), (k % 5 == 0) ? 1 : 0);
            check("m0_busy", 32'(busy_out[0]), 1);
        end
        // count is 2: start clears with no pulse
        start_in = 2'b01;
        step();
        start_in = 2'b00;
        check("m0_start_count", 32'(c0), 0);
        check("m0_start_tc", 32'(tc_out[0]), 0);
        step();
        check("m0_after_start", 32'(c0), 1);
        // Enable low holds the count
        enable_in = 2'b00;
        repeat (2) step();
        check("hold_count", 32'(c0), 1);
        check("hold_busy", 32'(busy_out[0]), 0);
        check("hold_tc", 32'(tc_out[0]), 0);
        enable_in = 2'b01;

        // Switch to one-shot, period 3: idle until start
        p0 = 8'd3;
        mode_in = 2'b01;
        repeat (2) step();
        check("m1_idle_count", 32'(c0), 1);
        check("m1_idle_busy", 32'(busy_out[0]), 0);
        start_in = 2'b01;
        step();
        start_in = 2'b00;
        check("m1_start_count", 32'(c0), 0);
        check("m1_start_busy", 32'(busy_out[0]), 1);
        check("m1_start_tc", 32'(tc_out[0]), 0);
        exp_c = '{1, 2, 0, 0, 0};
        exp_b = '{1, 1, 0, 0, 0};
        exp_t = '{0, 0, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            step();
            check("m1_count", 32'(c0), 32'(exp_c[k]));
            check("m1_busy", 32'(busy_out[0]), 32'(exp_b[k]));
            check("m1_tc", 32'(tc_out[0]), 32'(exp_t[k]));
        end

        // Period 0 on ch0, period 1 on ch1
        mode_in = 2'b00;
        p0 = 8'd0;
        p1 = 8'd1;
        enable_in = 2'b11;
        for (int k = 0; k < 3; k++) begin
            start_in = (k < 2) ? 2'b01 : 2'b00;
            mode_in  = (k == 1) ? 2'b01 : 2'b00;
            step();
            check("p0_count", 32'(c0), 0);
            check("p0_tc", 32'(tc_out[0]), 0);
            check("p0_busy", 32'(busy_out[0]), 0);
            check("p1_count", 32'(c1), 0);
            check("p1_tc", 32'(tc_out[1]), 1);
            check("p1_busy", 32'(busy_out[1]), 1);
        end
        start_in = 2'b00;
        mode_in = 2'b00;
        enable_in = 2'b01;
        p1 = 8'd0;

        // Period 10 run to 7, then period lowered to 4
        p0 = 8'd10;
        start_in = 2'b01;
        step();
        start_in = 2'b00;
        check("p10_start", 32'(c0), 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("p10_count", 32'(c0), 32'(k));
        end
        p0 = 8'd4;
        step();
        check("shrink_count", 32'(c0), 0);
        check("shrink_tc", 32'(tc_out[0]), 1);
        repeat (3) step();
        check("p4_count", 32'(c0), 3);
        // Start coincident with terminal advance
        start_in = 2'b01;
        step();
        start_in = 2'b00;
        check("start_term_count", 32'(c0), 0);
        check("start_term_tc", 32'(tc_out[0]), 0);
        step();
        check("start_term_next", 32'(c0), 1);

        // One-shot period 20, reset asserted asynchronously at count 6
        p0 = 8'd20;
        mode_in = 2'b01;
        start_in = 2'b01;
        step();
        start_in = 2'b00;
        repeat (6) step();
        check("os_count6", 32'(c0), 6);
        check("os_busy6", 32'(busy_out[0]), 1);
        #3;
        rst_in = 1'b1;
        #1;
        check("async_rst_count", 32'(count_out), 0);
        check("async_rst_busy", 32'(busy_out), 0);
        check("async_rst_tc", 32'(tc_out), 0);
        step();
        #3;
        rst_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_count", 32'(c0), 0);
            check("post_rst_busy", 32'(busy_out[0]), 0);
        end
        start_in = 2'b01;
        step();
        start_in = 2'b00;
        check("rearm_busy", 32'(busy_out[0]), 1);
        step();
        check("rearm_count", 32'(c0), 1);

`ifdef MULTI_PERIOD_COUNTER_PRESCALE_EN
        // Divided tick: PRESCALE 4, mode 0, period 2
        rst_in = 1'b1;
        mode_in = 2'b00;
        p0 = 8'd2;
        enable_in = 2'b01;
        step();
        check("pre_rst_count", 32'(c0), 0);
        rst_in = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("pre_count", 32'(c0), 32'((k / 4) % 2));
            check("pre_tc", 32'(tc_out[0]), (k % 8 == 0) ? 1 : 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
